// File: rtl/pulse_pkg.sv
// pulse_pkg: shared state encoding and default counter width for the pulse stretcher.
package pulse_pkg;
  localparam int COUNT_WIDTH_DEFAULT = 8;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/pulse_stretcher_register.sv
// pulse_stretcher_register: plain D register with asynchronous active-low clear to zero.
module pulse_stretcher_register #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q <= '0;
    else q <= d;
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches a one-cycle trigger into a level of programmable length,
// with optional retrigger, synchronous clear and registered done/dropped flags.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int RETRIGGER   = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pulse_in,
  input  logic [COUNT_WIDTH-1:0] length_in,
  input  logic                   clear_in,
  output logic                   level_out,
  output logic                   done_pulse_out,
  output logic                   dropped_pulse_out
);
  state_t state, state_next;
  logic [COUNT_WIDTH-1:0] remaining, remaining_next, len_eff;
  logic done_next, dropped_next;
  logic [2:0] q;
  pulse_stretcher_register #(.WIDTH(3)) u_reg (
    .clock  (clock),
    .reset_n(reset_n),
    .d      ({state_next, done_next, dropped_next}),
    .q      (q)
  );
  assign state             = state_t'(q[2]);
  assign done_pulse_out    = q[1];
  assign dropped_pulse_out = q[0];
  assign level_out         = (state == ACTIVE);
  // A zero length still yields a one-cycle level.
  assign len_eff = (length_in == '0) ? COUNT_WIDTH'(1) : length_in;
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    done_next      = 1'b0;
    dropped_next   = 1'b0;
    if (clear_in) begin
      state_next     = IDLE;
      remaining_next = '0;
    end else if (state == IDLE) begin
      if (pulse_in) begin
        state_next     = ACTIVE;
        remaining_next = len_eff;
      end
    end else if (pulse_in && RETRIGGER != 0) begin
      remaining_next = len_eff;
    end else begin
      dropped_next = pulse_in;
      if (remaining == COUNT_WIDTH'(1)) begin
        state_next     = IDLE;
        remaining_next = '0;
        done_next      = 1'b1;
      end else begin
        remaining_next = remaining - COUNT_WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) remaining <= '0;
    else remaining <= remaining_next;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed checks of both retrigger variants driven by a shared stimulus.
module tb_pulse_stretcher;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic pulse_in = 1'b0;
  logic clear_in = 1'b0;
  logic [7:0] length_in = '0;
  logic lvl_r, done_r, drop_r, lvl_d, done_d, drop_d;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pulse_stretcher #(.COUNT_WIDTH(8), .RETRIGGER(1)) dut_r (
    .clock(clock), .reset_n(reset_n), .pulse_in(pulse_in), .length_in(length_in),
    .clear_in(clear_in), .level_out(lvl_r), .done_pulse_out(done_r), .dropped_pulse_out(drop_r)
  );
  pulse_stretcher #(.COUNT_WIDTH(8), .RETRIGGER(0)) dut_d (
    .clock(clock), .reset_n(reset_n), .pulse_in(pulse_in), .length_in(length_in),
    .clear_in(clear_in), .level_out(lvl_d), .done_pulse_out(done_d), .dropped_pulse_out(drop_d)
  );

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pulse_in = 1'b0; clear_in = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  // Cycle 0 starts just after the first edge following reset release; length_in holds
  // a decoy value except in cycles where a pulse is driven.
  task automatic run(input string name, input logic [7:0] len, input logic [31:0] pm,
                     input logic [31:0] cm, input logic [31:0] lr, input logic [31:0] dr,
                     input logic [31:0] pr, input logic [31:0] ld, input logic [31:0] dd,
                     input logic [31:0] pd);
    do_reset();
    for (int c = 0; c < 24; c++) begin
      pulse_in  = pm[c];
      clear_in  = cm[c];
      length_in = pm[c] ? len : ~len;
      check($sformatf("%s.lvl_r@%0d", name, c), lvl_r, lr[c]);
      check($sformatf("%s.done_r@%0d", name, c), done_r, dr[c]);
      check($sformatf("%s.drop_r@%0d", name, c), drop_r, pr[c]);
      check($sformatf("%s.lvl_d@%0d", name, c), lvl_d, ld[c]);
      check($sformatf("%s.done_d@%0d", name, c), done_d, dd[c]);
      check($sformatf("%s.drop_d@%0d", name, c), drop_d, pd[c]);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2;
    check("reset.lvl_r", lvl_r, 1'b0);
    check("reset.done_r", done_r, 1'b0);
    check("reset.drop_d", drop_d, 1'b0);
    run("len4", 8'd4, rng(10,10), '0, rng(11,14), rng(15,15), '0,
        rng(11,14), rng(15,15), '0);
    run("retrig", 8'd3, rng(10,10) | rng(12,12), '0, rng(11,15), rng(16,16), '0,
        rng(11,13), rng(14,14), rng(13,13));
    run("retrig_last", 8'd3, rng(10,10) | rng(13,13), '0, rng(11,16), rng(17,17), '0,
        rng(11,13), rng(14,14), rng(14,14));
    run("zero", 8'd0, rng(10,10) | rng(12,12), '0, rng(11,11) | rng(13,13),
        rng(12,12) | rng(14,14), '0, rng(11,11) | rng(13,13), rng(12,12) | rng(14,14), '0);
    run("clear", 8'd8, rng(10,10) | rng(13,13), rng(13,13), rng(11,13), '0, '0,
        rng(11,13), '0, '0);
    begin : all_ones
      int high_cnt;
      do_reset();
      pulse_in = 1'b1; length_in = 8'hFF;
      @(posedge clock); #1;
      pulse_in = 1'b0; length_in = 8'h00;
      high_cnt = 0;
      for (int c = 0; c < 300 && lvl_r; c++) begin
        high_cnt++;
        @(posedge clock); #1;
      end
      check("ones.count255", high_cnt == 255, 1'b1);
      check("ones.done_r", done_r, 1'b1);
      check("ones.done_d", done_d, 1'b1);
    end
    begin : mid_reset
      do_reset();
      repeat (10) begin @(posedge clock); #1; end
      pulse_in = 1'b1; length_in = 8'd8;
      @(posedge clock); #1;
      pulse_in = 1'b0;
      @(posedge clock); #1;
      check("mreset.pre_lvl", lvl_r, 1'b1);
      #3 reset_n = 1'b0;
      #1;
      check("mreset.lvl_r", lvl_r, 1'b0);
      check("mreset.lvl_d", lvl_d, 1'b0);
      check("mreset.done_r", done_r, 1'b0);
      @(negedge clock) reset_n = 1'b1;
      pulse_in = 1'b1; length_in = 8'd8;
      @(posedge clock); #1;
      pulse_in = 1'b0;
      for (int c = 0; c < 8; c++) begin
        check($sformatf("mreset.hi@%0d", c), lvl_r, 1'b1);
        check($sformatf("mreset.nodone@%0d", c), done_r, 1'b0);
        @(posedge clock); #1;
      end
      check("mreset.lo", lvl_r, 1'b0);
      check("mreset.done", done_r, 1'b1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
